// File: rtl/escalonador_pkg.sv
// Shared types, default parameters and address helper for the quantum scheduler.
// Memory map: context-switch routine at 0, OS at 1000, program slot pid at 2000 + 1000*pid.
package escalonador_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      SWITCH
   } estado_t;

   localparam int N_PROC_DEF      = 3;
   localparam int PID_WIDTH_DEF   = 2;
   localparam int QUANTUM_DEF     = 16;
   localparam int QW_DEF          = 8;
   localparam int ADDR_WIDTH_DEF  = 32;
   localparam int BASE_PROG_DEF   = 2000;
   localparam int REGION_SIZE_DEF = 1000;
   localparam int TROCA_ADDR_DEF  = 0;

   // Evaluated in 64 bits so the caller can narrow it to its own address width.
   function automatic logic [63:0] base_de(input int unsigned pid,
                                           input int unsigned base_prog = BASE_PROG_DEF,
                                           input int unsigned region    = REGION_SIZE_DEF);
      return 64'(base_prog) + 64'(pid) * 64'(region);
   endfunction

endpackage

// File: rtl/escalonador_quantum_seletor.sv
// Round-robin pid picker: scans from start+1 upward, wrapping modulo N_PROC.
// The start pid itself is the last candidate and can be excluded (terminating program).
module seletor_round_robin
   import escalonador_pkg::*;
#(
   parameter int N_PROC    = N_PROC_DEF,
   parameter int PID_WIDTH = PID_WIDTH_DEF
) (
   input  logic [N_PROC-1:0]    ready,
   input  logic [PID_WIDTH-1:0] start,
   input  logic                 exclude_current,
   output logic                 found,
   output logic [PID_WIDTH-1:0] pid
);

   int                idx;
   logic [N_PROC-1:0] shifted;

   always_comb begin
      // NOTE: every output gets a default before the loop; otherwise a path that
      // never assigns it would infer a latch.
      found   = 1'b0;
      pid     = '0;
      idx     = 0;
      shifted = '0;
      for (int k = 1; k <= N_PROC; k++) begin
         idx     = (int'(start) + k) % N_PROC;
         shifted = ready >> idx;
         if (!found && shifted[0] && !(k == N_PROC && exclude_current)) begin
            found = 1'b1;
            pid   = PID_WIDTH'(idx);
         end
      end
   end

endmodule

// File: rtl/escalonador_quantum.sv
// Time-quantum round-robin scheduler: counts retired instructions, requests a jump to the
// context-switch routine on expiry or termination, and publishes the next pid and its base.
module escalonador_quantum
   import escalonador_pkg::*;
#(
   parameter int N_PROC      = N_PROC_DEF,
   parameter int PID_WIDTH   = PID_WIDTH_DEF,
   parameter int QUANTUM     = QUANTUM_DEF,
   parameter int QW          = QW_DEF,
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int BASE_PROG   = BASE_PROG_DEF,
   parameter int REGION_SIZE = REGION_SIZE_DEF,
   parameter int TROCA_ADDR  = TROCA_ADDR_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [N_PROC-1:0]     proc_ready,
   input  logic                  instr_retired,
   input  logic                  proc_done,
   input  logic                  ack_troca,
   output logic                  troca_req,
   output logic [ADDR_WIDTH-1:0] desvio_endereco,
   output logic [PID_WIDTH-1:0]  pid_atual,
   output logic [PID_WIDTH-1:0]  pid_proximo,
   output logic [ADDR_WIDTH-1:0] base_proximo,
   output logic [QW-1:0]         quantum_rest,
   output logic                  ocioso
);

   estado_t               state_q, state_d;
   logic                  troca_d;
   logic [PID_WIDTH-1:0]  pid_atual_d, pid_proximo_d;
   logic [ADDR_WIDTH-1:0] base_d;
   logic [QW-1:0]         quantum_d;

   logic                  sel_found;
   logic [PID_WIDTH-1:0]  sel_pid;
   logic [PID_WIDTH-1:0]  sel_start;
   logic                  sel_excl;
   logic                  termina, expira;

   assign desvio_endereco = ADDR_WIDTH'(TROCA_ADDR);

   // From IDLE the scan starts just past the last slot, so it returns the lowest ready pid.
   assign sel_start = (state_q == IDLE) ? PID_WIDTH'(N_PROC - 1) : pid_atual;
   assign sel_excl  = (state_q == RUN) && proc_done;

   assign termina = enable && proc_done;
   assign expira  = enable && instr_retired && (quantum_rest == QW'(1));

   seletor_round_robin #(
      .N_PROC    (N_PROC),
      .PID_WIDTH (PID_WIDTH)
   ) u_seletor (
      .ready           (proc_ready),
      .start           (sel_start),
      .exclude_current (sel_excl),
      .found           (sel_found),
      .pid             (sel_pid)
   );

   always_comb begin
      state_d       = state_q;
      troca_d       = troca_req;
      pid_atual_d   = pid_atual;
      pid_proximo_d = pid_proximo;
      base_d        = base_proximo;
      quantum_d     = quantum_rest;

      unique case (state_q)
         IDLE: begin
            if (enable && sel_found) begin
               pid_proximo_d = sel_pid;
               base_d        = ADDR_WIDTH'(base_de(32'(sel_pid), BASE_PROG, REGION_SIZE));
               troca_d       = 1'b1;
               state_d       = SWITCH;
            end
         end

         RUN: begin
            if (termina || expira) begin
               if (!sel_found) begin
                  troca_d = 1'b0;
                  state_d = IDLE;
               end else if (sel_pid == pid_atual) begin
                  quantum_d = QW'(QUANTUM);
               end else begin
                  pid_proximo_d = sel_pid;
                  base_d        = ADDR_WIDTH'(base_de(32'(sel_pid), BASE_PROG, REGION_SIZE));
                  troca_d       = 1'b1;
                  state_d       = SWITCH;
               end
            end else if (enable && instr_retired) begin
               quantum_d = quantum_rest - QW'(1);
            end
         end

         SWITCH: begin
            if (ack_troca) begin
               pid_atual_d = pid_proximo;
               quantum_d   = QW'(QUANTUM);
               troca_d     = 1'b0;
               state_d     = RUN;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      // NOTE: state registers use non-blocking assignment so every flop samples the
      // pre-edge values, independent of statement order.
      if (reset) begin
         state_q      <= IDLE;
         troca_req    <= 1'b0;
         pid_atual    <= '0;
         pid_proximo  <= '0;
         base_proximo <= ADDR_WIDTH'(BASE_PROG);
         quantum_rest <= QW'(QUANTUM);
         ocioso       <= 1'b1;
      end else begin
         state_q      <= state_d;
         troca_req    <= troca_d;
         pid_atual    <= pid_atual_d;
         pid_proximo  <= pid_proximo_d;
         base_proximo <= base_d;
         quantum_rest <= quantum_d;
         ocioso       <= (state_d == IDLE);
      end
   end

endmodule

// File: tb/tb_escalonador_quantum.sv
// Scenario bench for escalonador_quantum (N_PROC=3, QUANTUM=4): each row's expected outputs are
// queued when the row is driven and compared one cycle later, when the registered outputs appear.
module tb_escalonador_quantum;

   localparam int N_PROC     = 3;
   localparam int PID_WIDTH  = 2;
   localparam int QUANTUM    = 4;
   localparam int QW         = 8;
   localparam int ADDR_WIDTH = 32;

   logic                  clock;
   logic                  reset;
   logic                  enable;
   logic [N_PROC-1:0]     proc_ready;
   logic                  instr_retired;
   logic                  proc_done;
   logic                  ack_troca;
   logic                  troca_req;
   logic [ADDR_WIDTH-1:0] desvio_endereco;
   logic [PID_WIDTH-1:0]  pid_atual;
   logic [PID_WIDTH-1:0]  pid_proximo;
   logic [ADDR_WIDTH-1:0] base_proximo;
   logic [QW-1:0]         quantum_rest;
   logic                  ocioso;

   typedef struct packed {
      logic       rst;
      logic       en;
      logic [2:0] rdy;
      logic       ret;
      logic       done;
      logic       ack;
   } stim_t;

   typedef struct packed {
      logic        troca;
      logic [1:0]  pa;
      logic [1:0]  pp;
      logic [31:0] base;
      logic [7:0]  qr;
      logic        oc;
   } snap_t;

   snap_t sb [$];
   int    checks = 0;
   int    passed = 0;

   escalonador_quantum #(
      .N_PROC      (N_PROC),
      .PID_WIDTH   (PID_WIDTH),
      .QUANTUM     (QUANTUM),
      .QW          (QW),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .BASE_PROG   (2000),
      .REGION_SIZE (1000),
      .TROCA_ADDR  (0)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .enable          (enable),
      .proc_ready      (proc_ready),
      .instr_retired   (instr_retired),
      .proc_done       (proc_done),
      .ack_troca       (ack_troca),
      .troca_req       (troca_req),
      .desvio_endereco (desvio_endereco),
      .pid_atual       (pid_atual),
      .pid_proximo     (pid_proximo),
      .base_proximo    (base_proximo),
      .quantum_rest    (quantum_rest),
      .ocioso          (ocioso)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic stim_t st(input logic rst, input logic en, input logic [2:0] rdy,
                                input logic ret, input logic done, input logic ack);
      return '{rst: rst, en: en, rdy: rdy, ret: ret, done: done, ack: ack};
   endfunction

   // Expected outputs; the base is derived from the memory map 2000 + 1000*pid.
   function automatic snap_t ex(input logic troca, input int pa, input int pp,
                                input int qr, input logic oc);
      return '{troca: troca, pa: 2'(pa), pp: 2'(pp), base: 32'(2000 + 1000 * pp),
               qr: 8'(qr), oc: oc};
   endfunction

   function automatic snap_t sample();
      return '{troca: troca_req, pa: pid_atual, pp: pid_proximo, base: base_proximo,
               qr: quantum_rest, oc: ocioso};
   endfunction

   task automatic drive(input stim_t s);
      reset         = s.rst;
      enable        = s.en;
      proc_ready    = s.rdy;
      instr_retired = s.ret;
      proc_done     = s.done;
      ack_troca     = s.ack;
   endtask

   task automatic test_reset();
      stim_t s [$];
      snap_t e [$];
      snap_t act, exp_v;
      s.push_back(st(1, 1, 3'b111, 1, 1, 1)); e.push_back(ex(0, 0, 0, 4, 1));
      s.push_back(st(0, 0, 3'b111, 0, 0, 0)); e.push_back(ex(0, 0, 0, 4, 1));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]);
         sb.push_back(e[i]);
         @(posedge clock); #1;
         exp_v = sb.pop_front();
         act   = sample();
         checks++;
         if (act !== exp_v)
            $display("FAIL reset[%0d]: got troca=%0b pa=%0d pp=%0d base=%0d qr=%0d oc=%0b, want troca=%0b pa=%0d pp=%0d base=%0d qr=%0d oc=%0b",
                     i, act.troca, act.pa, act.pp, act.base, act.qr, act.oc,
                     exp_v.troca, exp_v.pa, exp_v.pp, exp_v.base, exp_v.qr, exp_v.oc);
         else
            passed++;
      end
      checks++;
      if (desvio_endereco !== 32'd0)
         $display("FAIL desvio_endereco: got %0d, want 0", desvio_endereco);
      else
         passed++;
   endtask

   task automatic test_dispatch();
      stim_t s [$];
      snap_t e [$];
      snap_t act, exp_v;
      s.push_back(st(0, 1, 3'b110, 0, 0, 0)); e.push_back(ex(1, 0, 1, 4, 0));
      s.push_back(st(0, 1, 3'b110, 0, 0, 0)); e.push_back(ex(1, 0, 1, 4, 0));
      s.push_back(st(0, 1, 3'b110, 0, 0, 1)); e.push_back(ex(0, 1, 1, 4, 0));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]);
         sb.push_back(e[i]);
         @(posedge clock); #1;
         exp_v = sb.pop_front();
         act   = sample();
         checks++;
         if (act !== exp_v)
            $display("FAIL dispatch[%0d]: got troca=%0b pa=%0d pp=%0d base=%0d qr=%0d oc=%0b, want troca=%0b pa=%0d pp=%0d base=%0d qr=%0d oc=%0b",
                     i, act.troca, act.pa, act.pp, act.base, act.qr, act.oc,
                     exp_v.troca, exp_v.pa, exp_v.pp, exp_v.base, exp_v.qr, exp_v.oc);
         else
            passed++;
      end
   endtask

   task automatic test_expiry();
      stim_t s [$];
      snap_t e [$];
      snap_t act, exp_v;
      s.push_back(st(0, 1, 3'b111, 1, 0, 0)); e.push_back(ex(0, 1, 1, 3, 0));
      s.push_back(st(0, 1, 3'b111, 1, 0, 0)); e.push_back(ex(0, 1, 1, 2, 0));
      s.push_back(st(0, 1, 3'b111, 0, 0, 0)); e.push_back(ex(0, 1, 1, 2, 0));
      s.push_back(st(0, 1, 3'b111, 1, 0, 0)); e.push_back(ex(0, 1, 1, 1, 0));
      s.push_back(st(0, 1, 3'b111, 1, 0, 0)); e.push_back(ex(1, 1, 2, 1, 0));
      s.push_back(st(0, 1, 3'b111, 1, 1, 0)); e.push_back(ex(1, 1, 2, 1, 0));
      s.push_back(st(0, 1, 3'b111, 0, 0, 1)); e.push_back(ex(0, 2, 2, 4, 0));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]);
         sb.push_back(e[i]);
         @(posedge clock); #1;
         exp_v = sb.pop_front();
         act   = sample();
         checks++;
         if (act !== exp_v)
            $display("FAIL expiry[%0d]: got troca=%0b pa=%0d pp=%0d base=%0d qr=%0d oc=%0b, want troca=%0b pa=%0d pp=%0d base=%0d qr=%0d oc=%0b",
                     i, act.troca, act.pa, act.pp, act.base, act.qr, act.oc,
                     exp_v.troca, exp_v.pa, exp_v.pp, exp_v.base, exp_v.qr, exp_v.oc);
         else
            passed++;
      end
   endtask

   task automatic test_termination();
      stim_t s [$];
      snap_t e [$];
      snap_t act, exp_v;
      s.push_back(st(0, 1, 3'b011, 0, 1, 0)); e.push_back(ex(1, 2, 0, 4, 0));
      s.push_back(st(0, 1, 3'b011, 0, 0, 1)); e.push_back(ex(0, 0, 0, 4, 0));
      s.push_back(st(0, 1, 3'b000, 0, 1, 0)); e.push_back(ex(0, 0, 0, 4, 1));
      s.push_back(st(0, 1, 3'b000, 1, 0, 1)); e.push_back(ex(0, 0, 0, 4, 1));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]);
         sb.push_back(e[i]);
         @(posedge clock); #1;
         exp_v = sb.pop_front();
         act   = sample();
         checks++;
         if (act !== exp_v)
            $display("FAIL termination[%0d]: got troca=%0b pa=%0d pp=%0d base=%0d qr=%0d oc=%0b, want troca=%0b pa=%0d pp=%0d base=%0d qr=%0d oc=%0b",
                     i, act.troca, act.pa, act.pp, act.base, act.qr, act.oc,
                     exp_v.troca, exp_v.pa, exp_v.pp, exp_v.base, exp_v.qr, exp_v.oc);
         else
            passed++;
      end
   endtask

   task automatic test_sole_reload();
      stim_t s [$];
      snap_t e [$];
      snap_t act, exp_v;
      s.push_back(st(0, 1, 3'b001, 0, 0, 0)); e.push_back(ex(1, 0, 0, 4, 0));
      s.push_back(st(0, 1, 3'b001, 0, 0, 1)); e.push_back(ex(0, 0, 0, 4, 0));
      s.push_back(st(0, 1, 3'b001, 1, 0, 0)); e.push_back(ex(0, 0, 0, 3, 0));
      s.push_back(st(0, 1, 3'b001, 1, 0, 0)); e.push_back(ex(0, 0, 0, 2, 0));
      s.push_back(st(0, 1, 3'b001, 1, 0, 0)); e.push_back(ex(0, 0, 0, 1, 0));
      s.push_back(st(0, 1, 3'b001, 1, 0, 0)); e.push_back(ex(0, 0, 0, 4, 0));
      s.push_back(st(0, 1, 3'b001, 1, 0, 0)); e.push_back(ex(0, 0, 0, 3, 0));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]);
         sb.push_back(e[i]);
         @(posedge clock); #1;
         exp_v = sb.pop_front();
         act   = sample();
         checks++;
         if (act !== exp_v)
            $display("FAIL sole_reload[%0d]: got troca=%0b pa=%0d pp=%0d base=%0d qr=%0d oc=%0b, want troca=%0b pa=%0d pp=%0d base=%0d qr=%0d oc=%0b",
                     i, act.troca, act.pa, act.pp, act.base, act.qr, act.oc,
                     exp_v.troca, exp_v.pa, exp_v.pp, exp_v.base, exp_v.qr, exp_v.oc);
         else
            passed++;
      end
   endtask

   // Done together with the last retire excludes the sole ready pid; then the
   // latched choice must survive proc_ready changes while the switch is pending.
   task automatic test_done_and_freeze();
      stim_t s [$];
      snap_t e [$];
      snap_t act, exp_v;
      s.push_back(st(0, 1, 3'b001, 1, 0, 0)); e.push_back(ex(0, 0, 0, 2, 0));
      s.push_back(st(0, 1, 3'b001, 1, 0, 0)); e.push_back(ex(0, 0, 0, 1, 0));
      s.push_back(st(0, 1, 3'b001, 1, 1, 0)); e.push_back(ex(0, 0, 0, 1, 1));
      s.push_back(st(0, 1, 3'b110, 0, 0, 0)); e.push_back(ex(1, 0, 1, 1, 0));
      s.push_back(st(0, 1, 3'b100, 0, 0, 0)); e.push_back(ex(1, 0, 1, 1, 0));
      s.push_back(st(0, 1, 3'b001, 0, 1, 0)); e.push_back(ex(1, 0, 1, 1, 0));
      s.push_back(st(0, 1, 3'b001, 0, 0, 1)); e.push_back(ex(0, 1, 1, 4, 0));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]);
         sb.push_back(e[i]);
         @(posedge clock); #1;
         exp_v = sb.pop_front();
         act   = sample();
         checks++;
         if (act !== exp_v)
            $display("FAIL done_and_freeze[%0d]: got troca=%0b pa=%0d pp=%0d base=%0d qr=%0d oc=%0b, want troca=%0b pa=%0d pp=%0d base=%0d qr=%0d oc=%0b",
                     i, act.troca, act.pa, act.pp, act.base, act.qr, act.oc,
                     exp_v.troca, exp_v.pa, exp_v.pp, exp_v.base, exp_v.qr, exp_v.oc);
         else
            passed++;
      end
   endtask

   task automatic test_reset_in_switch_and_enable();
      stim_t s [$];
      snap_t e [$];
      snap_t act, exp_v;
      s.push_back(st(0, 1, 3'b111, 0, 1, 0)); e.push_back(ex(1, 1, 2, 4, 0));
      s.push_back(st(1, 1, 3'b111, 0, 0, 1)); e.push_back(ex(0, 0, 0, 4, 1));
      s.push_back(st(0, 1, 3'b001, 0, 0, 0)); e.push_back(ex(1, 0, 0, 4, 0));
      s.push_back(st(0, 1, 3'b001, 0, 0, 1)); e.push_back(ex(0, 0, 0, 4, 0));
      s.push_back(st(0, 0, 3'b001, 1, 0, 0)); e.push_back(ex(0, 0, 0, 4, 0));
      s.push_back(st(0, 0, 3'b001, 1, 0, 0)); e.push_back(ex(0, 0, 0, 4, 0));
      s.push_back(st(0, 1, 3'b001, 1, 0, 0)); e.push_back(ex(0, 0, 0, 3, 0));
      s.push_back(st(0, 0, 3'b110, 0, 1, 0)); e.push_back(ex(0, 0, 0, 3, 0));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]);
         sb.push_back(e[i]);
         @(posedge clock); #1;
         exp_v = sb.pop_front();
         act   = sample();
         checks++;
         if (act !== exp_v)
            $display("FAIL reset_switch_enable[%0d]: got troca=%0b pa=%0d pp=%0d base=%0d qr=%0d oc=%0b, want troca=%0b pa=%0d pp=%0d base=%0d qr=%0d oc=%0b",
                     i, act.troca, act.pa, act.pp, act.base, act.qr, act.oc,
                     exp_v.troca, exp_v.pa, exp_v.pp, exp_v.base, exp_v.qr, exp_v.oc);
         else
            passed++;
      end
   endtask

   initial begin
      drive(st(1, 0, 3'b000, 0, 0, 0));
      test_reset();
      test_dispatch();
      test_expiry();
      test_termination();
      test_sole_reload();
      test_done_and_freeze();
      test_reset_in_switch_and_enable();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
